// File: rtl/dg_pkg.sv
// DAG shared definitions: widths, ureg group codes
// and the ureg address decoder.
package dg_pkg;

  localparam int DW   = 16;
  localparam int IW   = 3;
  localparam int AW   = 5;
  localparam int NREG = 1 << IW;

  localparam logic [1:0] GRP_I = 2'b00;
  localparam logic [1:0] GRP_M = 2'b01;
  localparam logic [1:0] GRP_L = 2'b10;
  localparam logic [1:0] GRP_B = 2'b11;

  typedef struct packed {
    logic [1:0]    grp;
    logic [IW-1:0] idx;
  } ureg_t;

  function automatic ureg_t ureg_dec(
    input logic [AW-1:0] a
  );
    ureg_t u;
    u.grp = a[AW-1:IW];
    u.idx = a[IW-1:0];
    return u;
  endfunction

endpackage

// File: rtl/dag_unit_if.sv
// Sequencer <-> DAG request, ureg access
// and DM address bundle.
interface dg_if;
  import dg_pkg::*;

  logic          ps_dg_en;
  logic          ps_dg_dgsclt;
  logic          ps_dg_mdfy;
  logic [IW-1:0] ps_dg_iadd;
  logic [IW-1:0] ps_dg_madd;
  logic          ps_dg_wrt_en;
  logic [AW-1:0] ps_dg_wrt_add;
  logic [AW-1:0] ps_dg_rd_add;
  logic [DW-1:0] bc_dt;
  logic [DW-1:0] dg_bc_dt;
  logic [DW-1:0] dg_dm_add;
  logic          dg_dm_vld;
  logic [DW-1:0] dg_ps_add;

  modport master (
    output ps_dg_en, ps_dg_dgsclt, ps_dg_mdfy,
    output ps_dg_iadd, ps_dg_madd,
    output ps_dg_wrt_en, ps_dg_wrt_add,
    output ps_dg_rd_add, bc_dt,
    input  dg_bc_dt, dg_dm_add, dg_dm_vld,
    input  dg_ps_add
  );

  modport slave (
    input  ps_dg_en, ps_dg_dgsclt, ps_dg_mdfy,
    input  ps_dg_iadd, ps_dg_madd,
    input  ps_dg_wrt_en, ps_dg_wrt_add,
    input  ps_dg_rd_add, bc_dt,
    output dg_bc_dt, dg_dm_add, dg_dm_vld,
    output dg_ps_add
  );

endinterface

// File: rtl/dg_circ_upd.sv
// Index + modifier add with single-step
// circular wrap into [B, B+L).
module dg_circ_upd
  import dg_pkg::*;
(
  input  logic [DW-1:0] i_i,
  input  logic [DW-1:0] m_i,
  input  logic [DW-1:0] l_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] nxt_o
);

  logic [DW-1:0] raw;
  logic [DW:0]   raw_x;
  logic [DW:0]   top_x;

  assign raw   = i_i + m_i;
  assign raw_x = {1'b0, raw};
  // 17-bit bound so B+L past 0xFFFF does not alias
  assign top_x = {1'b0, b_i} + {1'b0, l_i};

  always_comb begin
    nxt_o = raw;
    if (l_i != '0) begin
      if (raw_x >= top_x)
        nxt_o = raw - l_i;
      else if (raw < b_i)
        nxt_o = raw + l_i;
    end
  end

endmodule

// File: rtl/dag_unit.sv
// Data address generator: I/M/L/B files,
// one-cycle DM address output, ureg port.
module dag_unit
  import dg_pkg::*;
(
  input logic clk,
  input logic rst,
  dg_if.slave bus
);

  logic [DW-1:0] i_q [NREG];
  logic [DW-1:0] m_q [NREG];
  logic [DW-1:0] l_q [NREG];
  logic [DW-1:0] b_q [NREG];
  logic [DW-1:0] i_d [NREG];
  logic [DW-1:0] m_d [NREG];
  logic [DW-1:0] l_d [NREG];
  logic [DW-1:0] b_d [NREG];

  logic [DW-1:0] add_q, add_d;
  logic          vld_q;
  logic [DW-1:0] nxt;
  logic [DW-1:0] cur_i;
  logic [DW-1:0] rd_dt;
  ureg_t         wa, ra;

  assign wa    = ureg_dec(bus.ps_dg_wrt_add);
  assign ra    = ureg_dec(bus.ps_dg_rd_add);
  assign cur_i = i_q[bus.ps_dg_iadd];

  dg_circ_upd u_circ (
    .i_i   (cur_i),
    .m_i   (m_q[bus.ps_dg_madd]),
    .l_i   (l_q[bus.ps_dg_iadd]),
    .b_i   (b_q[bus.ps_dg_iadd]),
    .nxt_o (nxt)
  );

  always_comb begin
    add_d = add_q;
    if (bus.ps_dg_en)
      add_d = bus.ps_dg_dgsclt ? nxt : cur_i;
  end

  // Later assignments win: I write > B side load > modify
  always_comb begin
    i_d = i_q;
    m_d = m_q;
    l_d = l_q;
    b_d = b_q;
    if (bus.ps_dg_en && !bus.ps_dg_dgsclt &&
        bus.ps_dg_mdfy)
      i_d[bus.ps_dg_iadd] = nxt;
    if (bus.ps_dg_wrt_en) begin
      case (wa.grp)
        GRP_I: i_d[wa.idx] = bus.bc_dt;
        GRP_M: m_d[wa.idx] = bus.bc_dt;
        GRP_L: l_d[wa.idx] = bus.bc_dt;
        GRP_B: begin
          b_d[wa.idx] = bus.bc_dt;
          i_d[wa.idx] = bus.bc_dt;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) begin
        i_q[k] <= '0;
        m_q[k] <= '0;
        l_q[k] <= '0;
        b_q[k] <= '0;
      end
      add_q <= '0;
      vld_q <= 1'b0;
    end else begin
      i_q   <= i_d;
      m_q   <= m_d;
      l_q   <= l_d;
      b_q   <= b_d;
      add_q <= add_d;
      vld_q <= bus.ps_dg_en;
    end
  end

  always_comb begin
    rd_dt = '0;
    case (ra.grp)
      GRP_I:   rd_dt = i_q[ra.idx];
      GRP_M:   rd_dt = m_q[ra.idx];
      GRP_L:   rd_dt = l_q[ra.idx];
      GRP_B:   rd_dt = b_q[ra.idx];
      default: rd_dt = '0;
    endcase
    if (bus.ps_dg_wrt_en &&
        bus.ps_dg_wrt_add == bus.ps_dg_rd_add)
      rd_dt = bus.bc_dt;
  end

  assign bus.dg_bc_dt  = rd_dt;
  assign bus.dg_dm_add = add_q;
  assign bus.dg_ps_add = add_q;
  assign bus.dg_dm_vld = vld_q;

endmodule
